wave_gen: RTL and testbench
===========================

WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 Parameter WIDTH, default 8, bit width of sample and limit values (legal 2..16).
REQ-002 Parameter DIV_W, default 8, bit width of the tick divider.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = generator runs; 0 = freeze.
REQ-006 mode  input  2  0 triangle, 1 saw-up, 2 saw-down, 3 square.
REQ-007 low_in  input  WIDTH  lower output limit, inclusive.
REQ-008 high_in  input  WIDTH  upper output limit, inclusive.
REQ-009 step_in  input  WIDTH  increment per tick.
REQ-010 div_in  input  DIV_W  tick every div_in+1 enabled clocks.
REQ-011 wave_out  output  WIDTH  registered sample.
REQ-012 dir_out  output  1  current direction, 1 = rising.
REQ-013 wrap_out  output  1  one-clock pulse marking start of a new period.

Function
REQ-014 Prescaler SHALL count enabled clocks 0..div_in and assert internal tick when count >= div_in, then reload 0; count >= div_in after div_in is lowered SHALL tick on the next clock.
REQ-015 wave_out, dir_out, wrap_out SHALL change only on a tick edge; latency from tick to new wave_out is the same edge (registered).
REQ-016 All sum/difference comparisons SHALL use WIDTH+1 bits; no wrap-around through 0 or 2^WIDTH.
REQ-017 Triangle, rising: out+step >= high -> out=high, dir=0; else out+=step.
REQ-018 Triangle, falling: out <= low+step -> out=low, dir=1, wrap_out=1; else out-=step.
REQ-019 Saw-up: out+step > high -> out=low, wrap_out=1; else out+=step; dir_out held 1.
REQ-020 Saw-down: out < low+step -> out=high, wrap_out=1; else out-=step; dir_out held 0.
REQ-021 Square: each tick toggles out between low and high; transition to high sets dir=1, wrap_out=1; to low sets dir=0.
REQ-022 Out-of-range state at a tick (out<low or out>high, e.g. after limit change) SHALL clamp to nearest limit, dir pointing inward, no wrap pulse, overriding REQ-017..021 for that tick.
REQ-023 low_in >= high_in SHALL force out=low on every tick, dir=1, no wrap pulses.
REQ-024 step_in = 0 SHALL hold out at every tick in triangle/saw modes; square unaffected.
REQ-025 Mode change SHALL take effect on next tick; wave_out not reloaded; square entered from any value moves to high if out<high, else to low.
REQ-026 enable=0 SHALL hold wave_out and dir_out, zero prescaler count, and keep wrap_out 0; re-enable restarts divider from 0.
REQ-027 wrap_out SHALL be 0 on every non-tick clock.

Reset
REQ-028 rst_n low SHALL immediately set wave_out=0, dir_out=1, wrap_out=0, prescaler count=0, independent of clk.
REQ-029 First tick after reset release SHALL apply REQ-022 (clamp to low_in if low_in>0).
REQ-030 Reset mid-period SHALL discard all progress; no partial wrap pulse emitted.

Structure
REQ-031 Package wave_gen_pkg SHALL hold mode constants (MODE_TRI, MODE_SAW_UP, MODE_SAW_DN, MODE_SQUARE).
REQ-032 Divider SHALL be sub-module wave_prescaler (clk, rst_n, enable, div_in, tick_out); stepping logic stays in wave_gen.
REQ-033 Single always block for output state; no latches, no combinational path from inputs to outputs.

Verification
REQ-034 WIDTH=4, triangle, low=0, high=13, step=1, div=0 -> 0,1..13,12..0 repeating; period 26 clocks; wrap_out at each return to 0.
REQ-035 Same, low changed to 5 while out=2 -> next tick out=5, dir=1, no wrap; subsequent minimum 5, period 16.
REQ-036 Saw-up, low=2, high=10, step=3, div=1 -> 2,5,8,2... each value held 2 clocks; wrap_out on every return to 2.
REQ-037 Square, low=3, high=12, div=3 -> out alternates 12/3 every 4 clocks, wrap_out on each 3->12 edge.
REQ-038 low=9, high=9, any mode -> out constant 9, wrap_out never 1; enable=0 for 10 clocks freezes out and restarts divider.
REQ-039 rst_n pulsed low between clock edges mid-ramp -> outputs 0/1/0 immediately, before next clk edge.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared definitions for the waveform generator: the four output shapes
// selected by the mode input.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_TRI    = 2'd0,
        MODE_SAW_UP = 2'd1,
        MODE_SAW_DN = 2'd2,
        MODE_SQUARE = 2'd3
    } wave_mode_e;

endpackage

// File: rtl/wave_prescaler.sv
// Tick divider: one tick every div_in+1 enabled clocks, restarting from zero
// whenever the generator is disabled.
module wave_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick_out
);

    logic [DIV_W-1:0] count_q;

    // '>=' rather than '==' so lowering div_in below the running count ticks at once.
    assign tick_out = enable && (count_q >= div_in);

    // NOTE: non-blocking assignments for every register so all flops sample
    // the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!enable || tick_out) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/wave_gen.sv
// Programmable triangle / sawtooth / square generator with inclusive limits,
// per-tick step size and registered sample, direction and period-wrap outputs.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] low_in,
    input  logic [WIDTH-1:0] high_in,
    input  logic [WIDTH-1:0] step_in,
    input  logic [DIV_W-1:0] div_in,
    output logic [WIDTH-1:0] wave_out,
    output logic             dir_out,
    output logic             wrap_out
);

    logic             tick;
    logic [WIDTH-1:0] wave_q, wave_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    wave_mode_e       mode_s;

    // One extra bit so out+step and low+step never wrap through 2^WIDTH.
    logic [WIDTH:0] out_x, high_x, up_sum, low_plus;

    wave_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .div_in   (div_in),
        .tick_out (tick)
    );

    assign mode_s   = wave_mode_e'(mode);
    assign out_x    = {1'b0, wave_q};
    assign high_x   = {1'b0, high_in};
    assign up_sum   = out_x + {1'b0, step_in};
    assign low_plus = {1'b0, low_in} + {1'b0, step_in};

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        wave_d = wave_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        if (low_in >= high_in) begin
            wave_d = low_in;
            dir_d  = 1'b1;
        end else if (wave_q < low_in) begin
            wave_d = low_in;
            dir_d  = 1'b1;
        end else if (wave_q > high_in) begin
            wave_d = high_in;
            dir_d  = 1'b0;
        end else if (step_in != '0 || mode_s == MODE_SQUARE) begin
            case (mode_s)
                MODE_TRI: begin
                    if (dir_q) begin
                        if (up_sum >= high_x) begin
                            wave_d = high_in;
                            dir_d  = 1'b0;
                        end else begin
                            wave_d = up_sum[WIDTH-1:0];
                        end
                    end else if (out_x <= low_plus) begin
                        wave_d = low_in;
                        dir_d  = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        wave_d = wave_q - step_in;
                    end
                end
                MODE_SAW_UP: begin
                    dir_d = 1'b1;
                    if (up_sum > high_x) begin
                        wave_d = low_in;
                        wrap_d = 1'b1;
                    end else begin
                        wave_d = up_sum[WIDTH-1:0];
                    end
                end
                MODE_SAW_DN: begin
                    dir_d = 1'b0;
                    if (out_x < low_plus) begin
                        wave_d = high_in;
                        wrap_d = 1'b1;
                    end else begin
                        wave_d = wave_q - step_in;
                    end
                end
                default: begin
                    // Square: anything below high jumps up, which starts a new period.
                    if (wave_q < high_in) begin
                        wave_d = high_in;
                        dir_d  = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        wave_d = low_in;
                        dir_d  = 1'b0;
                    end
                end
            endcase
        end
    end

    // NOTE: the async reset clears all output state immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_q <= '0;
            dir_q  <= 1'b1;
            wrap_q <= 1'b0;
        end else if (tick) begin
            wave_q <= wave_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign wave_out = wave_q;
    assign dir_out  = dir_q;
    assign wrap_out = wrap_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen at WIDTH=4: a per-clock vector table plus
// hand-written reset sequences.
module tb_wave_gen;
    import wave_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] low_in = '0, high_in = '0, step_in = '0;
    logic [7:0] div_in = '0;
    logic [3:0] wave_out;
    logic       dir_out, wrap_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int en, md, lo, hi, st, dv;
        int w, d, wr;
    } vec_t;

    vec_t vecs[$];

    wave_gen #(.WIDTH(4), .DIV_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .low_in   (low_in),
        .high_in  (high_in),
        .step_in  (step_in),
        .div_in   (div_in),
        .wave_out (wave_out),
        .dir_out  (dir_out),
        .wrap_out (wrap_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int w, input int d, input int wr);
        check({tag, " wave"}, 32'(wave_out), 32'(w));
        check({tag, " dir"},  32'(dir_out),  32'(d));
        check({tag, " wrap"}, 32'(wrap_out), 32'(wr));
    endtask

    function automatic void push(int en, int md, int lo, int hi, int st, int dv,
                                 int w, int d, int wr);
        vecs.push_back('{en, md, lo, hi, st, dv, w, d, wr});
    endfunction

    task automatic drive(input int en, input int md, input int lo, input int hi,
                         input int st, input int dv);
        enable  = en[0];
        mode    = 2'(md);
        low_in  = 4'(lo);
        high_in = 4'(hi);
        step_in = 4'(st);
        div_in  = 8'(dv);
    endtask

    initial begin
        // Triangle 0..13, step 1, tick every clock
        for (int k = 1; k <= 13; k++) push(1, MODE_TRI, 0, 13, 1, 0, k, (k != 13) ? 1 : 0, 0);
        for (int k = 12; k >= 1; k--) push(1, MODE_TRI, 0, 13, 1, 0, k, 0, 0);
        push(1, MODE_TRI, 0, 13, 1, 0, 0, 1, 1);
        push(1, MODE_TRI, 0, 13, 1, 0, 1, 1, 0);
        push(1, MODE_TRI, 0, 13, 1, 0, 2, 1, 0);
        // Low raised to 5 while out=2: clamp, then 16-clock period with minimum 5
        push(1, MODE_TRI, 5, 13, 1, 0, 5, 1, 0);
        for (int v = 6; v <= 12; v++) push(1, MODE_TRI, 5, 13, 1, 0, v, 1, 0);
        push(1, MODE_TRI, 5, 13, 1, 0, 13, 0, 0);
        for (int v = 12; v >= 6; v--) push(1, MODE_TRI, 5, 13, 1, 0, v, 0, 0);
        push(1, MODE_TRI, 5, 13, 1, 0, 5, 1, 1);
        push(1, MODE_TRI, 5, 13, 1, 0, 6, 1, 0);
        // Zero step holds
        push(1, MODE_TRI, 5, 13, 0, 0, 6, 1, 0);
        push(1, MODE_TRI, 5, 13, 0, 0, 6, 1, 0);
        // Saw-up 2..10 step 3, two clocks per value
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 6, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 9, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 9, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 2, 1, 1);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 2, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 5, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 5, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 8, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 8, 1, 0);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 2, 1, 1);
        push(1, MODE_SAW_UP, 2, 10, 3, 1, 2, 1, 0);
        // Saw-down; lowering div below the running count ticks at once
        push(1, MODE_SAW_DN, 2, 10, 3, 0, 10, 0, 1);
        push(1, MODE_SAW_DN, 2, 10, 3, 0, 7, 0, 0);
        push(1, MODE_SAW_DN, 2, 10, 3, 0, 4, 0, 0);
        push(1, MODE_SAW_DN, 2, 10, 3, 0, 10, 0, 1);
        // Square 3/12, div 3, step 0 ignored
        for (int r = 0; r < 3; r++) push(1, MODE_SQUARE, 3, 12, 0, 3, 10, 0, 0);
        push(1, MODE_SQUARE, 3, 12, 0, 3, 12, 1, 1);
        for (int r = 0; r < 3; r++) push(1, MODE_SQUARE, 3, 12, 0, 3, 12, 1, 0);
        push(1, MODE_SQUARE, 3, 12, 0, 3, 3, 0, 0);
        for (int r = 0; r < 3; r++) push(1, MODE_SQUARE, 3, 12, 0, 3, 3, 0, 0);
        push(1, MODE_SQUARE, 3, 12, 0, 3, 12, 1, 1);
        // Equal limits in several modes
        push(1, MODE_TRI,    9, 9, 1, 0, 9, 1, 0);
        push(1, MODE_TRI,    9, 9, 1, 0, 9, 1, 0);
        push(1, MODE_SQUARE, 9, 9, 1, 0, 9, 1, 0);
        push(1, MODE_SQUARE, 9, 9, 1, 0, 9, 1, 0);
        push(1, MODE_SAW_DN, 9, 9, 1, 0, 9, 1, 0);
        // Partial divider count, then disable for 10 clocks, then restart
        push(1, MODE_SQUARE, 9, 9, 1, 2, 9, 1, 0);
        push(1, MODE_SQUARE, 9, 9, 1, 2, 9, 1, 0);
        for (int r = 0; r < 10; r++) push(0, MODE_TRI, 0, 13, 1, 2, 9, 1, 0);
        push(1, MODE_TRI, 0, 13, 1, 2, 9, 1, 0);
        push(1, MODE_TRI, 0, 13, 1, 2, 9, 1, 0);
        push(1, MODE_TRI, 0, 13, 1, 2, 10, 1, 0);
        push(1, MODE_TRI, 0, 13, 1, 2, 10, 1, 0);
        push(1, MODE_TRI, 0, 13, 1, 2, 10, 1, 0);
        push(1, MODE_TRI, 0, 13, 1, 2, 11, 1, 0);
        // Inverted limits force low
        push(1, MODE_TRI, 7, 4, 1, 0, 7, 1, 0);
        push(1, MODE_SAW_UP, 7, 4, 1, 0, 7, 1, 0);

        // Reset state, asserted between edges
        #2 rst_n = 1'b0;
        #1 check_out("reset", 0, 1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].md, vecs[i].lo, vecs[i].hi, vecs[i].st, vecs[i].dv);
            @(posedge clk);
            #1 check_out($sformatf("vec%0d", i), vecs[i].w, vecs[i].d, vecs[i].wr);
            @(negedge clk);
        end

        // Reset, then first tick clamps to low; reset right after a wrap pulse
        rst_n = 1'b0;
        #1 check_out("reset2", 0, 1, 0);
        @(negedge clk);
        drive(1, MODE_SAW_UP, 2, 4, 2, 0);
        rst_n = 1'b1;
        @(posedge clk); #1 check_out("saw_clamp", 2, 1, 0);
        @(posedge clk); #1 check_out("saw_step", 4, 1, 0);
        @(posedge clk); #1 check_out("saw_wrap", 2, 1, 1);
        #2 rst_n = 1'b0;
        #1 check_out("reset_mid", 0, 1, 0);
        @(negedge clk);
        drive(1, MODE_TRI, 4, 13, 1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1 check_out("post_reset_clamp", 4, 1, 0);
        @(posedge clk); #1 check_out("post_reset_step", 5, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
